// File: rtl/cube_pkg.sv
// Shared types and defaults for the cube colour sampler.
package cube_pkg;

    localparam int WIN_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Mean of two 8-bit values with a 9-bit intermediate so the carry is kept.
    function automatic logic [7:0] iir_blend(input logic [7:0] old_v, input logic [7:0] new_v);
        logic [8:0] s;
        s = {1'b0, old_v} + {1'b0, new_v};
        return s[8:1];
    endfunction

endpackage

// File: rtl/cube_color_sampler_channel_accum.sv
// One colour channel sum: clear, add one pixel, and the window average as the top byte.
module channel_accum
    import cube_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] pix_i,
    output logic [7:0] avg_o
);

    localparam int SW = 8 + 2 * WIN_LOG2;

    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] base;

    // Clear and add in the same cycle starts the new sum at this pixel.
    always_comb begin
        base  = clr_i ? '0 : sum_q;
        sum_d = add_i ? base + {{(2 * WIN_LOG2){1'b0}}, pix_i} : base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign avg_o = sum_q[SW-1 -: 8];

endmodule

// File: rtl/cube_color_sampler.sv
// Averages the RGB of a square window around the cube centre once per frame.
// Define CUBE_SAMPLER_IIR_EN to blend each new average with the previous published colour.
module cube_color_sampler
    import cube_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] PixX,
    input  logic [9:0] PixY,
    input  logic [7:0] Pix_R,
    input  logic [7:0] Pix_G,
    input  logic [7:0] Pix_B,
    input  logic [9:0] CubeX,
    input  logic [9:0] CubeY,
    output logic [7:0] Color_R,
    output logic [7:0] Color_G,
    output logic [7:0] Color_B,
    output logic       color_valid,
    output logic       sample_miss
);

    localparam int H  = 2 ** (WIN_LOG2 - 1);
    localparam int N  = 2 ** (2 * WIN_LOG2);
    localparam int CW = 2 * WIN_LOG2 + 1;

    localparam logic signed [10:0] H_S    = 11'(H);
    localparam logic signed [10:0] H_M1_S = 11'(H - 1);

    state_e          state_q, state_d;
    logic [9:0]      cx_q, cy_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    rgb8_t           acc_avg;
    rgb8_t           avg_q, avg_d;
    rgb8_t           color_q, color_d;
    logic            cv_q, miss_q, miss_d, pub_q, pub_d;

    logic [9:0]        cx_eff, cy_eff;
    logic signed [10:0] x_lo, x_hi, y_lo, y_hi, px_s, py_s;
    logic              in_win, accept;

    // A coincident frame_start pixel is judged against the new centre.
    assign cx_eff = frame_start ? CubeX : cx_q;
    assign cy_eff = frame_start ? CubeY : cy_q;

    assign x_lo = $signed({1'b0, cx_eff}) - H_S;
    assign x_hi = $signed({1'b0, cx_eff}) + H_M1_S;
    assign y_lo = $signed({1'b0, cy_eff}) - H_S;
    assign y_hi = $signed({1'b0, cy_eff}) + H_M1_S;
    assign px_s = $signed({1'b0, PixX});
    assign py_s = $signed({1'b0, PixY});

    assign in_win = (px_s >= x_lo) && (px_s <= x_hi) && (py_s >= y_lo) && (py_s <= y_hi);
    assign accept = pix_valid && in_win && (frame_start || (state_q == ST_ACCUM));

    channel_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_r (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (frame_start),
        .add_i (accept),
        .pix_i (Pix_R),
        .avg_o (acc_avg.r)
    );

    channel_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_g (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (frame_start),
        .add_i (accept),
        .pix_i (Pix_G),
        .avg_o (acc_avg.g)
    );

    channel_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_b (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (frame_start),
        .add_i (accept),
        .pix_i (Pix_B),
        .avg_o (acc_avg.b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        miss_d  = 1'b0;
        pub_d   = 1'b0;
        if (frame_start) begin
            miss_d  = (state_q == ST_ACCUM);
            state_d = ST_ACCUM;
            cnt_d   = accept ? CW'(1) : '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            state_d = ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    avg_d   = acc_avg;
                    pub_d   = 1'b1;
                    state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

`ifdef CUBE_SAMPLER_IIR_EN
    logic have_q;

    always_comb begin
        color_d = color_q;
        if (pub_q) begin
            if (have_q) begin
                color_d.r = iir_blend(color_q.r, avg_q.r);
                color_d.g = iir_blend(color_q.g, avg_q.g);
                color_d.b = iir_blend(color_q.b, avg_q.b);
            end else begin
                color_d = avg_q;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            have_q <= 1'b0;
        end else if (pub_q) begin
            have_q <= 1'b1;
        end
    end
`else
    always_comb begin
        color_d = color_q;
        if (pub_q) begin
            color_d = avg_q;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            color_q <= '0;
            cv_q    <= 1'b0;
            miss_q  <= 1'b0;
            pub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            color_q <= color_d;
            cv_q    <= pub_q;
            miss_q  <= miss_d;
            pub_q   <= pub_d;
            if (frame_start) begin
                cx_q <= CubeX;
                cy_q <= CubeY;
            end
        end
    end

    assign Color_R     = color_q.r;
    assign Color_G     = color_q.g;
    assign Color_B     = color_q.b;
    assign color_valid = cv_q;
    assign sample_miss = miss_q;

endmodule

// File: tb/tb_cube_color_sampler.sv
// Directed bench for cube_color_sampler with WIN_LOG2=4 (16x16 window, 256 samples).
module tb_cube_color_sampler;
    import cube_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] PixX, PixY, CubeX, CubeY;
    logic [7:0] Pix_R, Pix_G, Pix_B;
    logic [7:0] Color_R, Color_G, Color_B;
    logic       color_valid, sample_miss;

    int errors = 0;
    int checks = 0;
    int cv_cnt = 0;
    int miss_cnt = 0;

    int exp_r = 0, exp_g = 0, exp_b = 0;
    bit have_pub = 1'b0;

    cube_color_sampler #(.WIN_LOG2(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .PixX        (PixX),
        .PixY        (PixY),
        .Pix_R       (Pix_R),
        .Pix_G       (Pix_G),
        .Pix_B       (Pix_B),
        .CubeX       (CubeX),
        .CubeY       (CubeY),
        .Color_R     (Color_R),
        .Color_G     (Color_G),
        .Color_B     (Color_B),
        .color_valid (color_valid),
        .sample_miss (sample_miss)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (color_valid === 1'b1) cv_cnt <= cv_cnt + 1;
        if (sample_miss === 1'b1) miss_cnt <= miss_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_colors(input string tag, input int r, input int g, input int b);
        check({tag, "_r"}, {24'd0, Color_R}, r);
        check({tag, "_g"}, {24'd0, Color_G}, g);
        check({tag, "_b"}, {24'd0, Color_B}, b);
    endtask

    // Reference for what the next publish should show, given a fresh window average.
    task automatic model_publish(input int nr, input int ng, input int nb);
`ifdef CUBE_SAMPLER_IIR_EN
        if (have_pub) begin
            exp_r = (exp_r + nr) >> 1;
            exp_g = (exp_g + ng) >> 1;
            exp_b = (exp_b + nb) >> 1;
        end else begin
            exp_r = nr; exp_g = ng; exp_b = nb;
        end
`else
        exp_r = nr; exp_g = ng; exp_b = nb;
`endif
        have_pub = 1'b1;
    endtask

    // Streams a box one pixel wider than the window on each side; outside pixels are 0xFF.
    // mode 0: uniform uval, 1: R=X[7:0] G=Y[7:0] B=0x10, 2: 40/80/C0.
    task automatic stream(input int cx, input int cy, input bit with_fs, input bit coincident,
                          input bit exp_miss, input int mode, input logic [7:0] uval,
                          input int nmax, input string tag);
        int  sent;
        bit  inwin;
        sent = 0;
        if (with_fs) begin
            frame_start = 1'b1;
            CubeX = cx[9:0];
            CubeY = cy[9:0];
            if (coincident) begin
                PixX = 10'(cx - 8);
                PixY = 10'(cy - 8);
                Pix_R = 8'hFF; Pix_G = 8'hFF; Pix_B = 8'hFF;
                pix_valid = 1'b1;
                sent = 1;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge Clk);
            frame_start = 1'b0;
            pix_valid = 1'b0;
            CubeX = 10'd0;
            CubeY = 10'd0;
            check({tag, "_miss"}, {31'd0, sample_miss}, {31'd0, exp_miss});
        end
        for (int y = cy - 9; y <= cy + 8; y++) begin
            for (int x = cx - 9; x <= cx + 8; x++) begin
                if (sent >= nmax) break;
                if (x < 0 || y < 0 || x > 1023 || y > 1023) continue;
                if (coincident && x == cx - 8 && y == cy - 8) continue;
                inwin = (x >= cx - 8) && (x <= cx + 7) && (y >= cy - 8) && (y <= cy + 7);
                PixX = x[9:0];
                PixY = y[9:0];
                if (inwin) begin
                    case (mode)
                        0: begin Pix_R = uval; Pix_G = uval; Pix_B = uval; end
                        1: begin Pix_R = PixX[7:0]; Pix_G = PixY[7:0]; Pix_B = 8'h10; end
                        default: begin Pix_R = 8'h40; Pix_G = 8'h80; Pix_B = 8'hC0; end
                    endcase
                    sent++;
                end else begin
                    Pix_R = 8'hFF; Pix_G = 8'hFF; Pix_B = 8'hFF;
                end
                pix_valid = 1'b1;
                @(negedge Clk);
            end
        end
        pix_valid = 1'b0;
    endtask

    // Called on the negedge right after the edge that sampled the last window pixel.
    task automatic expect_publish(input string tag, input int nr, input int ng, input int nb);
        check({tag, "_cv_e0"}, {31'd0, color_valid}, 32'd0);
        check_colors({tag, "_hold"}, exp_r, exp_g, exp_b);
        @(negedge Clk);
        check({tag, "_cv_e1"}, {31'd0, color_valid}, 32'd0);
        @(negedge Clk);
        model_publish(nr, ng, nb);
        check({tag, "_cv_e2"}, {31'd0, color_valid}, 32'd1);
        check_colors(tag, exp_r, exp_g, exp_b);
        @(negedge Clk);
        check({tag, "_cv_pulse"}, {31'd0, color_valid}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        PixX = '0; PixY = '0; CubeX = '0; CubeY = '0;
        Pix_R = '0; Pix_G = '0; Pix_B = '0;
        repeat (3) @(negedge Clk);

        check_colors("rst", 0, 0, 0);
        check("rst_cv", {31'd0, color_valid}, 32'd0);
        check("rst_miss", {31'd0, sample_miss}, 32'd0);
        check("rst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        Reset = 1'b0;
        @(negedge Clk);

        // Pixels without any frame_start are ignored.
        stream(320, 240, 1'b0, 1'b0, 1'b0, 2, 8'h00, 256, "nofs");
        repeat (4) @(negedge Clk);
        check("nofs_cv_cnt", cv_cnt, 0);
        check("nofs_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});

        stream(320, 240, 1'b1, 1'b0, 1'b0, 2, 8'h00, 256, "uni");
        expect_publish("uni", 8'h40, 8'h80, 8'hC0);

        stream(320, 240, 1'b1, 1'b0, 1'b0, 1, 8'h00, 256, "grad");
        expect_publish("grad", 8'h3F, 8'hEF, 8'h10);

        // Pixels arriving in DONE change nothing.
        stream(320, 240, 1'b0, 1'b0, 1'b0, 0, 8'h00, 256, "done");
        repeat (4) @(negedge Clk);
        check("done_cv_cnt", cv_cnt, 2);
        check_colors("done_hold", exp_r, exp_g, exp_b);

        // Left edge clipped: 12 columns x 16 rows = 192 samples, never completes.
        stream(4, 100, 1'b1, 1'b0, 1'b0, 0, 8'h20, 256, "clip");
        repeat (4) @(negedge Clk);
        check("clip_cv_cnt", cv_cnt, 2);
        check("clip_state", {30'd0, dut.state_q}, {30'd0, ST_ACCUM});
        check_colors("clip_hold", exp_r, exp_g, exp_b);

        // New frame over the clipped one: miss pulse, and the 0xFF pixel is sample 1.
        stream(500, 300, 1'b1, 1'b1, 1'b1, 0, 8'h00, 256, "coin");
        check("coin_miss_cnt", miss_cnt, 1);
        expect_publish("coin", 8'h00, 8'h00, 8'h00);

        // Reset after 100 samples of a frame.
        stream(320, 240, 1'b1, 1'b0, 1'b0, 2, 8'h00, 100, "part");
        Reset = 1'b1;
        #1;
        have_pub = 1'b0;
        exp_r = 0; exp_g = 0; exp_b = 0;
        check_colors("midrst", 0, 0, 0);
        check("midrst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check("midrst_cv", {31'd0, color_valid}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        stream(320, 240, 1'b0, 1'b0, 1'b0, 2, 8'h00, 256, "rest");
        repeat (4) @(negedge Clk);
        check("rest_cv_cnt", cv_cnt, 3);

        stream(320, 240, 1'b1, 1'b0, 1'b0, 0, 8'h40, 256, "post1");
        expect_publish("post1", 8'h40, 8'h40, 8'h40);
        stream(320, 240, 1'b1, 1'b0, 1'b0, 0, 8'hC0, 256, "post2");
        expect_publish("post2", 8'hC0, 8'hC0, 8'hC0);
`ifdef CUBE_SAMPLER_IIR_EN
        check("iir_second", {24'd0, Color_R}, 32'h80);
`else
        check("direct_second", {24'd0, Color_R}, 32'hC0);
`endif
        repeat (3) @(negedge Clk);
        check("final_miss_cnt", miss_cnt, 1);
        check("final_cv_cnt", cv_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cube_color_sampler.md
CUBE_COLOR_SAMPLER -- requirements
Module: cube_color_sampler

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 4: the sample window is a square of side 2^WIN_LOG2 pixels.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse marking the start of a camera frame.
REQ-005 The block SHALL have port pix_valid, input, 1 bit: the pixel inputs are valid this cycle.
REQ-006 The block SHALL have ports PixX and PixY, input, 10 bits each: coordinates of the incoming pixel.
REQ-007 The block SHALL have ports Pix_R, Pix_G and Pix_B, input, 8 bits each: incoming pixel colour.
REQ-008 The block SHALL have ports CubeX and CubeY, input, 10 bits each: centre of the sample window.
REQ-009 The block SHALL have ports Color_R, Color_G and Color_B, output, 8 bits each: averaged cube colour.
REQ-010 The block SHALL have port color_valid, output, 1 bit: one-cycle pulse when the Color_* outputs are updated.
REQ-011 The block SHALL have port sample_miss, output, 1 bit: one-cycle pulse when a frame ended before the window was fully sampled.

Function
REQ-012 The block SHALL define H = 2^(WIN_LOG2-1) and N = 2^(2*WIN_LOG2).
REQ-013 The window SHALL be X in [CubeX-H, CubeX+H-1] and Y in [CubeY-H, CubeY+H-1], compared using 11-bit signed arithmetic so that a negative lower bound never matches.
REQ-014 CubeX and CubeY SHALL be latched on frame_start and held for the whole frame.
REQ-015 The state machine SHALL have four states: IDLE, ACCUM, DIVIDE and DONE.
REQ-016 Any state SHALL go to ACCUM on frame_start; on that transition the sums and the count are cleared, and sample_miss pulses if the prior state was ACCUM.
REQ-017 In ACCUM, a pix_valid pixel inside the window SHALL add Pix_R/G/B to per-channel sums of width 8+2*WIN_LOG2 and increment the count.
REQ-018 Accepting the Nth sample SHALL move the state to DIVIDE; DIVIDE SHALL go to DONE after one cycle.
REQ-019 In DIVIDE, the average SHALL be computed as sum >> (2*WIN_LOG2), i.e. truncated (floor).
REQ-020 The Color_* outputs SHALL be registered and SHALL update, with color_valid high, exactly 2 cycles after the edge that samples the Nth pixel.
REQ-021 In DONE and IDLE, all pixels SHALL be ignored.
REQ-022 If frame_start and an in-window pix_valid occur in the same cycle, the block SHALL use the new CubeX/CubeY, and the pixel SHALL count as sample 1 of the new frame.
REQ-023 A frame without frame_start SHALL never publish a result.

Reset
REQ-024 Reset SHALL force state IDLE, Color_R/G/B = 0, color_valid = 0, sample_miss = 0, and sums, count and latched centre = 0.
REQ-025 Reset asserted mid-ACCUM SHALL discard the partial sums, and no color_valid SHALL occur until a complete frame follows the next frame_start.

Configuration
REQ-026 With CUBE_SAMPLER_IIR_EN defined, each published value after the first publish since reset SHALL be (old + new) >> 1 per channel, computed in 9 bits.
REQ-027 With CUBE_SAMPLER_IIR_EN defined, the first publish after reset SHALL load the new average directly.
REQ-028 Without CUBE_SAMPLER_IIR_EN, the output SHALL be the new average directly, and no smoothing storage SHALL exist.

Structure
REQ-029 Package cube_pkg SHALL hold the WIN_LOG2 default constant, the state enum typedef, and an rgb8_t struct of three 8-bit channels.
REQ-030 Sub-module channel_accum SHALL hold one sum register with clear, add and shift-out, and SHALL be instantiated three times.

Verification (WIN_LOG2=4, window 16x16, N=256)
REQ-031 Uniform frame: CubeX=320, CubeY=240, all pixels R/G/B=0x40/0x80/0xC0 -> color_valid 2 cycles after the 256th in-window pixel; outputs 0x40/0x80/0xC0.
REQ-032 Gradient: Pix_R=PixX[7:0], window X 312..327 -> Color_R=0x3F (floor of 63.5).
REQ-033 Clipped window: CubeX=4 gives only 12 valid columns (192 samples) -> no color_valid; at the next frame_start, sample_miss pulses once and outputs are unchanged.
REQ-034 Reset mid-ACCUM at sample 100 -> outputs 0 and state IDLE; the following full frame publishes the correct average.
REQ-035 Coincident events: frame_start with an in-window pixel 0xFF plus 255 further pixels 0x00 -> Color_R=0x00 (sum 255 >> 8).
REQ-036 IIR enabled: first frame 0x40 publishes 0x40; second frame 0xC0 publishes 0x80.
